// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port multiplexers: platform constants,
// slot phase encoding and the slot-counter width helper.
package sram_pkg;

  localparam int SRAM_DW   = 16;
  localparam int SRAM_AW   = 18;
  localparam int IMEM_BASE = 0;
  localparam int DMEM_BASE = 1;

  typedef enum logic {
    PH_READ  = 1'b0,
    PH_WRITE = 1'b1
  } slot_phase_e;

  // Bits needed to count n states, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sram_slot_counter.sv
// Frame sequencer: slot counter, run flag gated by i_en at frame start,
// and the registered frame-start strobe.
module sram_slot_counter
  import sram_pkg::*;
#(
  parameter  int NPORTS = 2,
  localparam int SW     = clog2(2 * NPORTS)
) (
  input  logic          clk50,
  input  logic          rst_n,
  input  logic          i_en,
  output logic [SW-1:0] o_slot,
  output slot_phase_e   o_phase,
  output logic          o_active,
  output logic          o_frame_start
);

  localparam logic [SW-1:0] LAST = SW'(2 * NPORTS - 1);

  logic [SW-1:0] slot_q, slot_d;
  logic          running_q, running_d;
  logic          frame_start_q, frame_start_d;
  logic          active;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    slot_d        = slot_q;
    running_d     = running_q;
    frame_start_d = 1'b0;
    // At slot 0 the enable decides this very edge; elsewhere the frame is committed.
    active        = (slot_q == '0) ? i_en : running_q;
    if (slot_q == '0) begin
      running_d     = i_en;
      frame_start_d = i_en;
    end
    if (active) slot_d = (slot_q == LAST) ? '0 : slot_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      running_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      running_q     <= running_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_slot        = slot_q;
  assign o_phase       = slot_phase_e'(slot_q[0]);
  assign o_active      = active;
  assign o_frame_start = frame_start_q;

endmodule

// File: rtl/sram_port_mux.sv
// Time-multiplexes NPORTS read/write port pairs onto one asynchronous SRAM:
// each port gets a read slot then a write slot per frame, port 0 first.
module sram_port_mux
  import sram_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = 17,
  parameter int RAM_AW = 18,
  parameter int DW     = 16,
  parameter int BASE   = 0
) (
  input  logic                 clk50,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [NPORTS*AW-1:0] i_rd_addr,
  input  logic [NPORTS*AW-1:0] i_wr_addr,
  input  logic [NPORTS*DW-1:0] i_wr_data,
  input  logic [NPORTS-1:0]    i_wr_en,
  output logic [NPORTS*DW-1:0] o_rd_data,
  output logic [NPORTS-1:0]    o_rd_valid,
  output logic                 o_frame_start,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic                 ram_oe,
  output logic                 ram_we,
  output logic [DW-1:0]        ram_dq_out,
  output logic                 ram_dq_oe,
  input  logic [DW-1:0]        ram_dq_in
);

  localparam int SW = clog2(2 * NPORTS);
  localparam int PW = (SW > 1) ? SW - 1 : 1;
  localparam logic [RAM_AW-AW-1:0] BASE_BITS = (RAM_AW - AW)'(BASE);

  logic [SW-1:0] slot;
  slot_phase_e   phase;
  logic          active;
  logic [PW-1:0] port_idx;
  logic [AW-1:0] rd_addr_sel, wr_addr_sel;
  logic [DW-1:0] wr_data_sel;
  logic          wr_en_sel;

  logic [NPORTS*DW-1:0] rd_data_q;
  logic [NPORTS-1:0]    rd_valid_q;
  logic [RAM_AW-1:0]    ram_addr_q;
  logic                 ram_oe_q, ram_we_q, ram_dq_oe_q;
  logic [DW-1:0]        ram_dq_out_q;

  sram_slot_counter #(.NPORTS(NPORTS)) u_slot (
    .clk50         (clk50),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .o_slot        (slot),
    .o_phase       (phase),
    .o_active      (active),
    .o_frame_start (o_frame_start)
  );

  assign port_idx    = PW'(slot >> 1);
  assign rd_addr_sel = i_rd_addr[port_idx*AW +: AW];
  assign wr_addr_sel = i_wr_addr[port_idx*AW +: AW];
  assign wr_data_sel = i_wr_data[port_idx*DW +: DW];
  assign wr_en_sel   = i_wr_en[port_idx];

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q    <= '0;
      rd_valid_q   <= '0;
      ram_addr_q   <= '0;
      ram_oe_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_dq_oe_q  <= 1'b0;
      ram_dq_out_q <= '0;
    end else begin
      rd_valid_q <= '0;
      if (!active) begin
        // Idle bus keeps its last address so the pads do not toggle.
        ram_oe_q    <= 1'b0;
        ram_we_q    <= 1'b0;
        ram_dq_oe_q <= 1'b0;
      end else if (phase == PH_READ) begin
        ram_addr_q  <= {BASE_BITS, rd_addr_sel};
        ram_oe_q    <= 1'b1;
        ram_we_q    <= 1'b0;
        ram_dq_oe_q <= 1'b0;
      end else begin
        // Data from the read issued one cycle earlier is on the pads now.
        rd_data_q[port_idx*DW +: DW] <= ram_dq_in;
        rd_valid_q[port_idx]         <= 1'b1;
        ram_addr_q                   <= {BASE_BITS, wr_addr_sel};
        ram_oe_q                     <= 1'b0;
        ram_we_q                     <= wr_en_sel;
        ram_dq_oe_q                  <= wr_en_sel;
        if (wr_en_sel) ram_dq_out_q <= wr_data_sel;
      end
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign ram_addr   = ram_addr_q;
  assign ram_oe     = ram_oe_q;
  assign ram_we     = ram_we_q;
  assign ram_dq_oe  = ram_dq_oe_q;
  assign ram_dq_out = ram_dq_out_q;

endmodule
